reg16bit: RTL and testbench

REG16BIT -- requirements
Module: reg16bit

---
 rtl/reg16bit.sv | 64 ++++++
 tb/tb_reg16bit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/reg16bit.sv
// reg16bit: 16-bit capture register with valid, change-detect and popcount flags.
// Optional registered parity output when REG16BIT_PARITY_EN is defined.
module reg16bit #(
    parameter logic [15:0] RESET_VALUE = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d,
    output logic [15:0] q,
    output logic        q_valid,
    output logic        changed,
`ifdef REG16BIT_PARITY_EN
    output logic        parity,
`endif
    output logic [4:0]  ones
);
    function automatic logic [4:0] popcnt(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) n = n + {4'b0, v[i]};
        return n;
    endfunction

    logic [15:0] q_q, q_d;
    logic        valid_q;
    logic        changed_q, changed_d;
    logic [4:0]  ones_q, ones_d;

    // Flags are derived from d at the capturing edge so they always match q.
    always_comb begin
        q_d       = d;
        changed_d = d != q_q;
        ones_d    = popcnt(d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q       <= RESET_VALUE;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            ones_q    <= popcnt(RESET_VALUE);
        end else begin
            q_q       <= q_d;
            valid_q   <= 1'b1;
            changed_q <= changed_d;
            ones_q    <= ones_d;
        end
    end

`ifdef REG16BIT_PARITY_EN
    logic parity_q, parity_d;
    always_comb parity_d = ^d;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) parity_q <= ^RESET_VALUE;
        else      parity_q <= parity_d;
    end
    assign parity = parity_q;
`endif

    assign q       = q_q;
    assign q_valid = valid_q;
    assign changed = changed_q;
    assign ones    = ones_q;
endmodule

// File: tb/tb_reg16bit.sv
// tb_reg16bit: table-driven and scoreboard checks for reg16bit, plus hand-written
// reset/hold sequences; checks parity too when REG16BIT_PARITY_EN is defined.
module tb_reg16bit;
    typedef struct packed {
        logic [15:0] q;
        logic        v;
        logic        c;
        logic [4:0]  ones;
        logic        p;
    } out_t;

    typedef struct packed {
        logic        rst;
        logic [15:0] d;
        out_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] d = 16'h1234;
    logic [15:0] q;
    logic        q_valid, changed;
    logic [4:0]  ones;
    logic        parity;
    int          n_vec = 0;
    int          n_err = 0;
    out_t        sb[$];
    logic [15:0] m_q;

    always #5 clk = ~clk;

    reg16bit dut (
        .clk(clk), .rst(rst), .d(d), .q(q), .q_valid(q_valid), .changed(changed),
`ifdef REG16BIT_PARITY_EN
        .parity(parity),
`endif
        .ones(ones)
    );
`ifndef REG16BIT_PARITY_EN
    assign parity = 1'b0;
`endif

    task automatic check(input string name, input out_t e);
        out_t a;
        a = '{q: q, v: q_valid, c: changed, ones: ones, p: parity};
`ifndef REG16BIT_PARITY_EN
        e.p = 1'b0;
`endif
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got q=%h valid=%b changed=%b ones=%0d parity=%b, want q=%h valid=%b changed=%b ones=%0d parity=%b",
                     name, a.q, a.v, a.c, a.ones, a.p, e.q, e.v, e.c, e.ones, e.p);
        end
    endtask

    task automatic apply(input string name, input logic r, input logic [15:0] dv, input out_t e);
        @(negedge clk);
        rst = r;
        d = dv;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check(name, sb.pop_front());
    endtask

    localparam out_t RST = '{q: 16'h0000, v: 1'b0, c: 1'b0, ones: 5'd0, p: 1'b0};

    initial begin
        vec_t tbl[12];
        out_t e;
        tbl[0]  = '{1'b0, 16'h1234, RST};
        tbl[1]  = '{1'b0, 16'hFFFF, RST};
        tbl[2]  = '{1'b1, 16'hAAAA, '{16'hAAAA, 1'b1, 1'b1, 5'd8,  1'b0}};
        tbl[3]  = '{1'b1, 16'h5555, '{16'h5555, 1'b1, 1'b1, 5'd8,  1'b0}};
        tbl[4]  = '{1'b1, 16'h5555, '{16'h5555, 1'b1, 1'b0, 5'd8,  1'b0}};
        tbl[5]  = '{1'b1, 16'h0000, '{16'h0000, 1'b1, 1'b1, 5'd0,  1'b0}};
        tbl[6]  = '{1'b1, 16'h0000, '{16'h0000, 1'b1, 1'b0, 5'd0,  1'b0}};
        tbl[7]  = '{1'b1, 16'h8001, '{16'h8001, 1'b1, 1'b1, 5'd2,  1'b0}};
        tbl[8]  = '{1'b1, 16'hF0F0, '{16'hF0F0, 1'b1, 1'b1, 5'd8,  1'b0}};
        tbl[9]  = '{1'b1, 16'hFFFF, '{16'hFFFF, 1'b1, 1'b1, 5'd16, 1'b0}};
        tbl[10] = '{1'b1, 16'hFFFF, '{16'hFFFF, 1'b1, 1'b0, 5'd16, 1'b0}};
        tbl[11] = '{1'b1, 16'h0001, '{16'h0001, 1'b1, 1'b1, 5'd1,  1'b1}};

        #1 check("por", RST);
        foreach (tbl[i]) apply($sformatf("tbl%0d", i), tbl[i].rst, tbl[i].d, tbl[i].e);

        // d toggling between edges must not reach q
        apply("cap1234", 1'b1, 16'h1234, '{16'h1234, 1'b1, 1'b1, 5'd5, 1'b1});
        #1 d = 16'hFFFF;
        #1 check("hold_a", '{16'h1234, 1'b1, 1'b1, 5'd5, 1'b1});
        #1 d = 16'h0000;
        #1 check("hold_b", '{16'h1234, 1'b1, 1'b1, 5'd5, 1'b1});

        // asynchronous reset mid-cycle, then clocks while held
        apply("cap5555", 1'b1, 16'h5555, '{16'h5555, 1'b1, 1'b1, 5'd8, 1'b0});
        #3 rst = 1'b0;
        #1 check("async_rst", RST);
        d = 16'hABCD;
        @(posedge clk); #1 check("rst_hold1", RST);
        @(posedge clk); #1 check("rst_hold2", RST);

        // release at negedge: no capture until next rising edge
        @(negedge clk);
        rst = 1'b1;
        d = 16'hF0F0;
        #1 check("release", RST);
        @(posedge clk); #1 check("capF0F0", '{16'hF0F0, 1'b1, 1'b1, 5'd8, 1'b0});
        apply("capFFFF", 1'b1, 16'hFFFF, '{16'hFFFF, 1'b1, 1'b1, 5'd16, 1'b0});

        // capturing the reset value right after release: valid but no change
        apply("rst_again", 1'b0, 16'h7777, RST);
        apply("cap_rv", 1'b1, 16'h0000, '{16'h0000, 1'b1, 1'b0, 5'd0, 1'b0});
        m_q = 16'h0000;

        for (int i = 0; i < 40; i++) begin
            logic [15:0] r;
            r = (i % 5 == 4) ? m_q : 16'($urandom);
            e = '{r, 1'b1, r != m_q, 5'($countones(r)), ^r};
            apply($sformatf("rnd%0d", i), 1'b1, r, e);
            m_q = r;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end
endmodule
